// File: rtl/systolic_mac_array_if.sv
// systolic_mac_array_if
//   Bundles the job-input stream, the result-row readout stream and the
//   status/debug outputs of systolic_mac_array.
//
//   Handshake rule for both streams: a transfer happens on a rising clock edge
//   where valid and ready are both high. The source holds its payload steady
//   while valid is high and ready is low. The sink may raise or lower ready
//   freely.
//
//   Signals (direction seen from the engine, modport slave):
//     mode      in  [1:0]     reduction (00 OR, 01 XOR, 10 ADD, 11 OR), first beat only
//     in_valid  in            a_col/b_row/in_last valid
//     in_ready  out           input beat accepted when in_valid & in_ready
//     a_col     in  [N-1:0]   column k of A, bit i = row i
//     b_row     in  [N-1:0]   row k of B, bit j = column j
//     in_last   in            final beat of the job
//     out_valid out           out_data holds a result row
//     out_ready in            row consumed when out_valid & out_ready
//     out_data  out [N*ACC_W-1:0] C[r][j] at bits [j*ACC_W +: ACC_W]
//     out_last  out           high together with row N-1
//     busy      out           job in progress (LOAD, DRAIN, READ)
//     sat       out           sticky ADD saturation flag for the current job
//     dbg_state out [1:0]     FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 READ)
interface systolic_mac_array_if #(
  parameter int N     = 4,
  parameter int ACC_W = 4
);
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       a_col;
  logic [N-1:0]       b_row;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [N*ACC_W-1:0] out_data;
  logic               out_last;
  logic               busy;
  logic               sat;
  logic [1:0]         dbg_state;

  modport master (
    output mode, in_valid, a_col, b_row, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, sat, dbg_state
  );

  modport slave (
    input  mode, in_valid, a_col, b_row, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, sat, dbg_state
  );
endinterface

// File: rtl/systolic_mac_array.sv
// systolic_mac_array
//   N x N systolic bit-matrix multiply/accumulate engine. A job is a stream of
//   K beats (a_k, b_k). Each cell (i,j) reduces the product bits a_k[i] & b_k[j]
//   over k with OR, XOR or saturating ADD into an ACC_W-bit accumulator. The
//   result is then read out one row per handshake.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    systolic_mac_array_if.slave (streams, status, debug state)
//
//   Dataflow: the a bits travel right along each row and the b bits travel
//   down each column. Row i's a bit is pre-delayed by i stages and column j's
//   b bit by j stages, so cell (i,j) sees beat k exactly i+j steps after the
//   beat is accepted. The array advances only on an accepted beat or during
//   DRAIN. Input bubbles therefore never shift the skew.
module systolic_mac_array #(
  parameter int N     = 4,
  parameter int ACC_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_mac_array_if.slave   bus
);

  localparam int CW = $clog2(2 * N);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  localparam logic [1:0] M_OR  = 2'b00;
  localparam logic [1:0] M_XOR = 2'b01;
  localparam logic [1:0] M_ADD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;
  logic          sat_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] row_q;
  logic [1:0]    mode_q;

  logic          accept;
  logic          first_beat;
  logic          step;
  logic [1:0]    mode_in;
  logic [1:0]    eff_mode;
  logic [N-1:0]  inj_a;
  logic [N-1:0]  inj_b;
  logic          sat_any;

  // Per-cell operands, flattened as index i*N+j.
  logic [N*N-1:0]       a_w;
  logic [N*N-1:0]       b_w;
  logic [N*N-1:0]       v_w;
  logic [N*N-1:0]       hit_w;
  logic [N*N*ACC_W-1:0] acc_w;
  logic [N*ACC_W-1:0]   row_data;

  assign accept     = bus.in_valid & in_ready_q;
  assign first_beat = accept & (state_q == S_IDLE);
  assign step       = accept | (state_q == S_DRAIN);
  assign mode_in    = (bus.mode == 2'b11) ? M_OR : bus.mode;
  // The first beat is reduced with the mode on the bus, before mode_q is loaded.
  assign eff_mode   = first_beat ? mode_in : mode_q;
  // During DRAIN, zeros with valid low are pushed in to flush the skew.
  assign inj_a      = accept ? bus.a_col : '0;
  assign inj_b      = accept ? bus.b_row : '0;
  assign sat_any    = |hit_w;

  // Row skew: row i's a bit and beat-valid are delayed by i steps.
  for (genvar i = 0; i < N; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_w[0] = inj_a[0];
      assign v_w[0] = accept;
    end else begin : g_shift
      logic [i-1:0] sa_q;
      logic [i-1:0] sv_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sa_q <= '0;
          sv_q <= '0;
        end else if (step) begin
          sa_q[0] <= inj_a[i];
          sv_q[0] <= accept;
          for (int d = 1; d < i; d++) begin
            sa_q[d] <= sa_q[d-1];
            sv_q[d] <= sv_q[d-1];
          end
        end
      end
      assign a_w[i*N] = sa_q[i-1];
      assign v_w[i*N] = sv_q[i-1];
    end
  end

  // Column skew: column j's b bit is delayed by j steps.
  for (genvar j = 0; j < N; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_w[0] = inj_b[0];
    end else begin : g_shift
      logic [j-1:0] sb_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sb_q <= '0;
        end else if (step) begin
          sb_q[0] <= inj_b[j];
          for (int d = 1; d < j; d++) begin
            sb_q[d] <= sb_q[d-1];
          end
        end
      end
      assign b_w[j] = sb_q[j-1];
    end
  end

  // Cell array.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int C = i * N + j;
      logic [ACC_W-1:0] acc_q;
      logic [ACC_W-1:0] acc_d;
      logic [ACC_W-1:0] base;
      logic             p;
      logic             hit;

      always_comb begin
        // On the first beat the pipeline has already flushed, so only
        // cell (0,0) can see a product. Every cell restarts from zero.
        base  = first_beat ? '0 : acc_q;
        p     = v_w[C] & a_w[C] & b_w[C];
        acc_d = base;
        hit   = 1'b0;
        case (eff_mode)
          M_XOR:   acc_d[0] = base[0] ^ p;
          M_ADD: begin
            if (p) begin
              if (&base) hit = 1'b1;
              else       acc_d = base + ACC_W'(1);
            end
          end
          default: acc_d[0] = base[0] | p;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset)     acc_q <= '0;
        else if (step) acc_q <= acc_d;
      end

      assign hit_w[C]                  = hit & step;
      assign acc_w[C*ACC_W +: ACC_W]   = acc_q;

      if (j < N - 1) begin : g_fwd_a
        logic a_fw_q;
        logic v_fw_q;
        always_ff @(posedge clk) begin
          if (reset) begin
            a_fw_q <= 1'b0;
            v_fw_q <= 1'b0;
          end else if (step) begin
            a_fw_q <= a_w[C];
            v_fw_q <= v_w[C];
          end
        end
        assign a_w[C+1] = a_fw_q;
        assign v_w[C+1] = v_fw_q;
      end

      if (i < N - 1) begin : g_fwd_b
        logic b_fw_q;
        always_ff @(posedge clk) begin
          if (reset)     b_fw_q <= 1'b0;
          else if (step) b_fw_q <= b_w[C];
        end
        assign b_w[C+N] = b_fw_q;
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      row_q       <= '0;
      mode_q      <= M_OR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mode_q <= mode_in;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.in_last) begin
              state_q    <= S_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept && bus.in_last) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        S_DRAIN: begin
          // The final beat reaches cell (N-1,N-1) 2N-2 steps after acceptance.
          // The counter leaves margin so every cell has settled before readout.
          if (cnt_q == DRAIN_LAST) begin
            state_q     <= S_READ;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            row_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_READ: begin
          if (bus.out_ready) begin
            if (row_q == ROW_LAST) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              row_q       <= '0;
            end else begin
              row_q      <= row_q + RW'(1);
              out_last_q <= ((row_q + RW'(1)) == ROW_LAST);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky saturation: restarted by the first beat, then accumulates hits.
  always_ff @(posedge clk) begin
    if (reset)           sat_q <= 1'b0;
    else if (first_beat) sat_q <= sat_any;
    else if (step)       sat_q <= sat_q | sat_any;
  end

  always_comb begin
    row_data = '0;
    if (out_valid_q) begin
      for (int j = 0; j < N; j++) begin
        row_data[j*ACC_W +: ACC_W] = acc_w[(int'(row_q) * N + j) * ACC_W +: ACC_W];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = row_data;
  assign bus.busy      = busy_q;
  assign bus.sat       = sat_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
module tb_systolic_mac_array;
  localparam int N     = 4;
  localparam int ACC_W = 4;
  localparam int DW    = N * ACC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mac_array_if #(.N(N), .ACC_W(ACC_W)) bus ();
  systolic_mac_array #(.N(N), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_sat;
  logic [N-1:0]  ja[64];
  logic [N-1:0]  jb[64];
  int            last_edge;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: C[i][j] = reduce over k of a_k[i] & b_k[j].
  task automatic model_job(input logic [1:0] m, input int k);
    int acc[N][N];
    int maxv;
    logic [DW-1:0] row;
    maxv    = (1 << ACC_W) - 1;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) acc[i][j] = 0;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          int p;
          p = (ja[b][i] & jb[b][j]) ? 1 : 0;
          case (m)
            2'b01: acc[i][j] = acc[i][j] ^ p;
            2'b10: if (p == 1) begin
                     if (acc[i][j] == maxv) exp_sat = 1'b1;
                     else acc[i][j] = acc[i][j] + 1;
                   end
            default: acc[i][j] = acc[i][j] | p;
          endcase
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) row[j*ACC_W +: ACC_W] = ACC_W'(acc[i][j]);
      exp_q.push_back(row);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beats(input logic [1:0] m, input int count, input bit final_last,
                            input bit bubbles);
    for (int b = 0; b < count; b++) begin
      if (bubbles) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.a_col    = ja[b];
      bus.b_row    = jb[b];
      bus.in_last  = final_last && (b == count - 1);
      bus.mode     = (b == 0) ? m : 2'($urandom_range(0, 3));
      begin
        int  guard;
        bit  took;
        guard = 0;
        took  = 1'b0;
        while (!took && guard < 50) begin
          took = bus.in_ready;
          tick();
          guard++;
        end
        if (!took) check_val("in_ready_timeout", 64'd0, 64'd1);
      end
      if (b == count - 1) last_edge = cyc;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic read_result(input int stall_row, input int stall_len, input bit poke);
    int guard;
    check_val("data_zero_before_valid", 64'(bus.out_data), 64'd0);
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      tick();
      guard++;
    end
    if (!bus.out_valid) begin
      check_val("out_valid_timeout", 64'd0, 64'd1);
      exp_q.delete();
      return;
    end
    check_val("latency", 64'(cyc - last_edge), 64'(2 * N));
    for (int r = 0; r < N; r++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      if (r == stall_row && stall_len > 0) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          if (poke) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a_col    = N'($urandom);
            bus.b_row    = N'($urandom);
          end
          tick();
          check_val("stall_data", 64'(bus.out_data), 64'(e));
          check_val("stall_last", 64'(bus.out_last), 64'(r == N - 1));
          check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      check_val("row_valid", 64'(bus.out_valid), 64'd1);
      check_val("row_data", 64'(bus.out_data), 64'(e));
      check_val("row_last", 64'(bus.out_last), 64'(r == N - 1));
      check_val("sat", 64'(bus.sat), 64'(exp_sat));
      tick();
    end
    check_val("post_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("post_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("post_busy", 64'(bus.busy), 64'd0);
    check_val("post_sat_hold", 64'(bus.sat), 64'(exp_sat));
  endtask

  task automatic run_job(input logic [1:0] m, input int k, input bit bubbles,
                         input int stall_row, input int stall_len, input bit poke);
    model_job(m, k);
    send_beats(m, k, 1'b1, bubbles);
    read_result(stall_row, stall_len, poke);
  endtask

  task automatic fill_const(input int k, input logic [N-1:0] v);
    for (int b = 0; b < k; b++) begin
      ja[b] = v;
      jb[b] = v;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.mode      = 2'b00;
    bus.in_valid  = 1'b0;
    bus.a_col     = '0;
    bus.b_row     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    last_edge     = 0;
    exp_sat       = 1'b0;
    tick();
    tick();
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_sat", 64'(bus.sat), 64'd0);
    check_val("rst_out_data", 64'(bus.out_data), 64'd0);
    check_val("rst_out_last", 64'(bus.out_last), 64'd0);
    reset = 1'b0;
    tick();

    // OR identity: diagonal result.
    for (int b = 0; b < N; b++) begin
      ja[b] = N'(1 << b);
      jb[b] = N'(1 << b);
    end
    run_job(2'b00, N, 1'b0, -1, 0, 1'b0);

    // XOR then OR of two all-ones beats; back-to-back jobs.
    fill_const(2, '1);
    run_job(2'b01, 2, 1'b0, -1, 0, 1'b0);
    run_job(2'b00, 2, 1'b0, -1, 0, 1'b0);

    // ADD with bubbles, then saturation.
    fill_const(20, '1);
    run_job(2'b10, 3, 1'b1, -1, 0, 1'b0);
    run_job(2'b10, 20, 1'b0, -1, 0, 1'b0);

    // Backpressure on row 1 with in_valid pokes during READ.
    for (int b = 0; b < 5; b++) begin
      ja[b] = N'($urandom);
      jb[b] = N'($urandom);
    end
    run_job(2'b10, 5, 1'b1, 1, 5, 1'b1);

    // Reset in the middle of LOAD, then a tiny OR job.
    fill_const(2, '1);
    send_beats(2'b10, 2, 1'b0, 1'b0);
    check_val("midjob_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("abort_state", 64'(bus.dbg_state), 64'd0);
    ja[0] = N'(1);
    jb[0] = N'(1);
    run_job(2'b00, 1, 1'b0, -1, 0, 1'b0);

    // Randomized jobs, all modes including 11.
    for (int t = 0; t < 8; t++) begin
      int k;
      k = $urandom_range(1, 20);
      for (int b = 0; b < k; b++) begin
        ja[b] = N'($urandom);
        jb[b] = N'($urandom);
      end
      run_job(2'($urandom_range(0, 3)), k, 1'b1, $urandom_range(0, N - 1),
              $urandom_range(0, 3), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Parametrised N×N systolic bit-matrix multiply/accumulate engine, the next-generation coprocessor core behind the Tiny Tapeout top level. It accepts a stream of K column/row vector pairs (a_k, b_k) and computes C[i][j] = reduce over k of (a_k[i] & b_k[j]). The reduction is selectable per job: OR, XOR (GF(2) product) or saturating integer ADD into ACC_W-bit accumulators. Both the input stream and the row-by-row result readout use valid/ready handshakes, so the top level can throttle either side.

## Interface
- N, default 4: array dimension (2..8); vectors are N bits, result matrix N×N.
- ACC_W, default 4: accumulator width per cell (1..8).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- mode  in  2  reduction: 00 OR, 01 XOR, 10 ADD (saturating), 11 treated as OR; sampled on the first beat of a job.
- in_valid  in  1  a_col/b_row/in_last valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- a_col  in  N  column k of A; bit i is row i.
- b_row  in  N  row k of B; bit j is column j.
- in_last  in  1  marks final beat (K = beats accepted, K ≥ 1).
- out_valid  out  1  out_data holds a result row.
- out_ready  in  1  row consumed when out_valid & out_ready.
- out_data  out  N*ACC_W  row i: C[i][j] at bits [j*ACC_W +: ACC_W].
- out_last  out  1  high with row N-1.
- busy  out  1  high in LOAD, DRAIN, READ.
- sat  out  1  sticky: an ADD accumulator saturated during the current job.

## Operation
- States: IDLE, LOAD, DRAIN, READ.
- IDLE: in_ready=1. The first accepted beat clears all accumulators and sat, latches mode, and is processed as k=0. If in_last=0, go to LOAD; if in_last=1, go to DRAIN.
- LOAD: in_ready=1. Each accepted beat is processed. A beat with in_last=1 goes to DRAIN. Cycles with in_valid=0 are bubbles: no accumulation, no skew advance corruption (skew registers shift only on accepted beats or in DRAIN).
- Internal skew: cell (i,j) sees beat k at a delay of i+j. Bubbles must not change results.
- DRAIN: in_ready=0. Lasts exactly 2N-1 cycles, then go to READ with row index 0.
- READ: in_ready=0, out_valid=1, out_data = row r. On handshake r increments. The handshake on row N-1 (out_last=1) returns to IDLE.
- Reduction per cell when the product bit p = a[i]&b[j] arrives:
  - OR: acc[0] |= p.
  - XOR: acc[0] ^= p.
  - OR and XOR keep acc[ACC_W-1:1] = 0.
  - ADD: acc = min(acc + p, 2^ACC_W - 1). Any increment attempted at max sets sat.
- in_valid while in_ready=0 is ignored. The mode input is ignored except on the first beat.

## Timing
- Reset values: state IDLE, all accumulators 0, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, sat=0.
- out_data is 0 whenever out_valid=0.
- Latency: last beat accepted at edge T; DRAIN covers cycles T+1..T+2N-1; out_valid=1 from cycle T+2N.
- Readout is N cycles minimum with out_ready held high.
- Under backpressure, out_data, out_last and r hold stable while out_valid & !out_ready.
- in_ready returns to 1 the cycle after the final readout handshake. Back-to-back jobs add no extra gap.
- Reset mid-job (any state) aborts it. The next cycle is identical to post-reset, and no partial result ever appears.
- sat is valid from DRAIN onward and holds until the next job's first beat.

## Test plan
- Reset: assert 2 cycles -> in_ready=1, out_valid=0, busy=0, sat=0, out_data=0.
- OR identity, N=4, ACC_W=4: beats k=0..3 with a=b=1<<k, last on k=3 -> rows 0x0001, 0x0010, 0x0100, 0x1000. First out_valid exactly 8 cycles after the last beat edge.
- Two beats with a=b=0xF:
  - XOR -> all rows 0x0000.
  - Same stimulus in OR -> all rows 0x1111.
- ADD, a=b=0xF:
  - 3 beats with random in_valid bubbles -> rows 0x3333, sat=0.
  - 20 beats -> rows 0xFFFF, sat=1.
- Backpressure: hold out_ready=0 for 5 cycles on row 1 -> out_data stable, no row skipped, out_last only on row 3. in_valid pulses during READ are ignored.
- Reset after 2 LOAD beats, then an OR job with K=1, a=0x1, b=0x1 -> rows 0x0001, 0x0000, 0x0000, 0x0000.
